// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes them to IMEM
// from IMEM_BASE_ADDR and holds the core in reset until done. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned       AWIDTH         = 32,
    parameter int unsigned       DWIDTH         = 32,
    parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = 'h0100_0000,
    parameter int unsigned       MAX_WORDS      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_write_en_o,
    output logic              mem_read_en_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       words_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       word_idx;
    logic [1:0]        byte_idx;
    logic [15:0]       len_q;
    logic [DWIDTH-1:0] word_q;
    logic              accept;
    logic              can_start;
    logic              go_recv;
    logic              last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q;
    logic [31:0]       trailer;
    assign trailer      = {byte_i, word_q[23:0]};
    assign byte_ready_o = (state_q == S_RECV) || (state_q == S_CHK);
    assign busy_o       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHK);
`else
    assign byte_ready_o = (state_q == S_RECV);
    assign busy_o       = (state_q == S_RECV) || (state_q == S_WRITE);
`endif

    assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign go_recv   = can_start && start_i && (len_i != 16'd0) && ({1'b0, len_i} <= MAX_LEN);
    assign accept    = byte_valid_i && byte_ready_o;
    assign last_word = (word_idx + 16'd1) == len_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    if (len_i == 16'd0)                  state_d = S_DONE;
                    else if ({1'b0, len_i} > MAX_LEN)    state_d = S_ERR;
                    else                                 state_d = S_RECV;
                end
            end
            S_RECV: if (accept && byte_idx == 2'd3) state_d = S_WRITE;
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = last_word ? S_CHK : S_RECV;
`else
                state_d = last_word ? S_DONE : S_RECV;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept && byte_idx == 2'd3)
                    state_d = ((sum_q + trailer) == 32'd0) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control counters: the only state that reset touches besides the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
            byte_idx <= '0;
        end else begin
            if (go_recv) begin
                word_idx <= '0;
                byte_idx <= '0;
                len_q    <= len_i;
            end else begin
                if (accept)              byte_idx <= byte_idx + 2'd1;
                if (state_q == S_WRITE)  word_idx <= word_idx + 16'd1;
            end
        end
    end

    // Word assembly and running sum; the trailer reuses the word register while in CHK.
    always_ff @(posedge clk) begin
        if (accept) word_q[{byte_idx, 3'b000} +: 8] <= byte_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (go_recv)                 sum_q <= '0;
        else if (state_q == S_WRITE) sum_q <= sum_q + word_q;
`endif
    end

    assign mem_write_en_o = (state_q == S_WRITE);
    assign mem_read_en_o  = 1'b0;
    assign mem_addr_o     = IMEM_BASE_ADDR + AWIDTH'({word_idx, 2'b00});
    assign mem_wdata_o    = mem_write_en_o ? word_q : '0;
    assign core_rst_o     = (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign err_o          = (state_q == S_ERR);
    assign words_o        = word_idx;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a byte stream into instruction memory before the core runs, the writer side of the read-only fetch path. It sits between an external byte source and the memory write port (`addr_i`/`wdata_i`/`write_en_i`). It assembles little-endian 32-bit words and writes them to consecutive addresses from `IMEM_BASE_ADDR`. It holds the fetch/decode core in reset until the load completes.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width; only 32 supported
- `IMEM_BASE_ADDR`, 32'h0100_0000, address of word 0
- `MAX_WORDS`, 1024, largest accepted load length
- `clk` in 1: the block's single clock
- `rst` in 1: reset, synchronous, active-high
- `start_i` in 1: begin a load; honoured in IDLE, DONE, ERR
- `len_i` in 16: word count, sampled when `start_i` is accepted
- `byte_valid_i` in 1: source byte valid
- `byte_i` in 8: source byte
- `byte_ready_o` out 1: loader can accept a byte
- `mem_addr_o` out AWIDTH: memory write address
- `mem_wdata_o` out DWIDTH: memory write data
- `mem_write_en_o` out 1: memory write strobe
- `mem_read_en_o` out 1: constant 0
- `core_rst_o` out 1: reset to fetch/decode; high unless in DONE
- `busy_o` out 1: high in RECV, WRITE and CHK
- `done_o` out 1: level, high in DONE
- `err_o` out 1: level, high in ERR
- `words_o` out 16: words written so far in the current load

## Operation
- States: IDLE, RECV, WRITE, CHK (macro only), DONE, ERR.
- IDLE or DONE or ERR with `start_i` set:
  - `len_i`==0 → DONE.
  - `len_i` > MAX_WORDS → ERR.
  - Otherwise → RECV; clear the word index, byte index and `words_o`.
- `start_i` in RECV, WRITE or CHK is ignored.
- RECV:
  - `byte_ready_o`=1.
  - A byte is accepted on a cycle where `byte_valid_i && byte_ready_o`. Byte k (0..3) goes to bits [8k+7:8k] of the word register.
  - Acceptance of byte 3 → WRITE.
- WRITE, one cycle:
  - `mem_write_en_o`=1, `mem_addr_o` = IMEM_BASE_ADDR + 4·word_idx, `mem_wdata_o` = assembled word.
  - Word index and `words_o` increment.
  - If the incremented index equals len → DONE (or CHK with the macro); otherwise → RECV.
- Address arithmetic is AWIDTH-bit, modulo 2^AWIDTH; word_idx is 16 bits.
- DONE: `core_rst_o`=0, so the core fetches from IMEM_BASE_ADDR. Restarting with `start_i` reasserts `core_rst_o` the next cycle.
- ERR: `core_rst_o`=1; stays in ERR until `start_i` or `rst`.
- `rst` at any time, mid-word included: return to IDLE and discard any partial word. Memory contents already written are untouched.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready_o` 0, `mem_write_en_o` 0, `mem_read_en_o` 0
  - `mem_addr_o` IMEM_BASE_ADDR, `mem_wdata_o` 0
  - `core_rst_o` 1, `busy_o` 0, `done_o` 0, `err_o` 0
  - `words_o` 0
- All outputs are registered or decoded from registered state only; no combinational path from the stream inputs to outputs.
- `start_i` sampled at edge T → `busy_o` high from T+1.
- Minimum throughput is 5 cycles per word: 4 accept cycles, then 1 WRITE cycle with `byte_ready_o`=0.
- Source stalls (`byte_valid_i`=0) hold the state and byte index indefinitely.
- The last WRITE is at cycle W; `done_o`=1 and `core_rst_o`=0 from W+1. With the macro, this happens one cycle after the final checksum byte is accepted.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of written words is kept.
  - After the last WRITE, go to CHK with `byte_ready_o`=1 and accept 4 little-endian trailer bytes.
  - Sum + trailer == 0 → DONE; otherwise → ERR.
  - The sum is cleared on start.
- Undefined: no CHK state, no trailer bytes; the last WRITE goes directly to DONE.

## Test plan
- Reset then `start_i`, len=2; bytes 13 00 00 00 93 00 10 00 → writes 0x00000013 @0x01000000, 0x00100093 @0x01000004; `done_o`=1; `core_rst_o`=0; `words_o`=2.
- `byte_valid_i` toggling every other cycle, len=1, bytes EF BE AD DE → single write 0xDEADBEEF; `byte_ready_o`=0 only on the WRITE cycle.
- len=0 → DONE one cycle after start with no write; len=1025 → `err_o`=1, `core_rst_o`=1; then `start_i` with len=1 leaves ERR.
- `rst` after 2 bytes of word 1 → IDLE, `words_o`=0, `mem_write_en_o` stays 0. A new load of 1 word writes at 0x01000000.
- `start_i` pulsed mid-RECV → ignored; the load completes with the original length.
- With the macro, len=1, word 0x00000001 and trailer FF FF FF FF → DONE; trailer 00 00 00 00 → ERR.
